axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- AXI4-Lite master that turns a simple single-beat command/response interface into AW/W/B or AR/R transactions.
- Sits directly upstream of the AXI4-Lite memory slave (axi2mem) and drives all five of its channels.
- One transaction is outstanding at a time; there are no bursts and no WSTRB (the slave writes full words).

Parameters:
ADDR_WIDTH, 32, byte address width on command and AXI address channels
DATA_WIDTH, 32, data width on command, W and R channels

Ports:
i_w_aclk  in  1  clock; all logic rising-edge
i_w_areset_n  in  1  reset, asynchronous, active-low
i_w_cmd_valid  in  1  command request
o_w_cmd_ready  out  1  command accepted when valid&ready
i_w_cmd_write  in  1  1=write, 0=read
i_w_cmd_addr  in  ADDR_WIDTH  target address
i_w_cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
o_w_rsp_valid  out  1  response available
i_w_rsp_ready  in  1  response consumed when valid&ready
o_w_rsp_write  out  1  response belongs to a write
o_w_rsp_resp  out  2  BRESP/RRESP captured from slave
o_w_rsp_rdata  out  DATA_WIDTH  RDATA (0 for writes)
o_w_err_sticky  out  1  set on any non-OKAY response; cleared only by reset
o_w_awvalid  out  1  AW valid
i_w_awready  in  1  AW ready
o_w_awaddr  out  ADDR_WIDTH  AW address
o_w_wvalid  out  1  W valid
i_w_wready  in  1  W ready
o_w_wdata  out  DATA_WIDTH  W data
i_w_bvalid  in  1  B valid
o_w_bready  out  1  B ready
i_w_bresp  in  2  B response
o_w_arvalid  out  1  AR valid
i_w_arready  in  1  AR ready
o_w_araddr  out  ADDR_WIDTH  AR address
i_w_rvalid  in  1  R valid
o_w_rready  out  1  R ready
i_w_rresp  in  2  R response
i_w_rdata  in  DATA_WIDTH  R data

Behaviour:
- Reset (asynchronous, active-low on i_w_areset_n; clock i_w_aclk):
  - State goes to IDLE.
  - All valid/ready outputs are 0 except o_w_cmd_ready.
  - o_w_cmd_ready = (state==IDLE) combinationally, so it reads 1 in reset; commands presented during reset are not accepted.
  - Address, data and response registers reset to 0; o_w_err_sticky resets to 0.
- All AXI and rsp outputs are registered. o_w_cmd_ready is the only combinational output.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - On cmd_valid&cmd_ready, latch addr and wdata into the AXI address/data registers.
  - If write: next state WR_AW_W, and awvalid and wvalid both go to 1 on the next cycle (1-cycle latency from accept).
  - If read: next state RD_AR, and arvalid goes to 1 on the next cycle.
- WR_AW_W:
  - Two independent done-flags, aw_done and w_done.
  - awvalid drops on the cycle after awvalid&awready; wvalid drops on the cycle after wvalid&wready. Either may complete first, or both may complete in the same cycle.
  - Once a valid is asserted it holds, with stable addr/data, until accepted.
  - When both handshakes have completed (the flags, or this cycle's handshakes), go to WR_B with bready=1.
- WR_B:
  - bready=1. On bvalid&bready, capture bresp, set rsp_write=1 and rsp_rdata=0, then go to RSP.
  - bready drops on the same edge.
- RD_AR: arvalid holds until arvalid&arready. Then arvalid goes to 0, rready goes to 1, and the state goes to RD_R.
- RD_R: on rvalid&rready, capture rdata and rresp, set rsp_write=0, drop rready, and go to RSP.
- RSP:
  - rsp_valid=1, holding stable until rsp_valid&rsp_ready. Then rsp_valid goes to 0 and the state returns to IDLE.
  - Earliest next command accept is the cycle after rsp_valid deasserts (cmd_ready=1 in IDLE).
- o_w_err_sticky is set on the edge that captures any resp != 2'b00.
- Minimum latency with an always-ready slave:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: accept at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- Slave signals arriving outside their wait state are ignored: bvalid outside WR_B, rvalid outside RD_R, and awready/wready/arready while the corresponding valid is 0.
- No timeout: the block waits indefinitely on a stalled slave.
- Reset mid-transaction: all valids and readies drop immediately (asynchronously). The transaction is discarded with no response generated; the slave is reset by the same signal.

Test Plan:
- Write addr=0x10, data=0xDEADBEEF, slave awready=wready=bready-path immediate, bresp=00 -> awvalid&wvalid at cycle 1, rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, err_sticky=0.
- Write with wready delayed 3 cycles after awready -> awvalid drops after its handshake, wvalid held with 0xDEADBEEF until accepted, exactly one AW and one W handshake, a single response.
- Read addr=0x10, rdata=0xDEADBEEF, rvalid delayed 4 cycles, rsp_ready held low 2 cycles -> rready held high until R handshake; rsp_rdata=0xDEADBEEF stable while rsp_valid=1; cmd_ready stays 0 until rsp is consumed.
- Read returning rresp=2'b10 -> rsp_resp=10, err_sticky=1 and remains 1 through a subsequent OKAY write.
- Back-to-back write then read with rsp_ready tied high -> second command accepted the cycle after the first rsp_valid drops; no overlap between the AW/W and AR channels.
- Assert i_w_areset_n=0 while awvalid=1 awaiting awready -> awvalid=0 immediately, state IDLE, no rsp_valid after reset release.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Purpose : AXI4-Lite master turning single-beat read/write commands into
//           AW/W/B or AR/R transactions, one transaction outstanding at a time.
// Ports   : i_w_aclk/i_w_areset_n clock and async active-low reset;
//           i_w_cmd_* / o_w_cmd_ready command in (valid/ready);
//           o_w_rsp_* / i_w_rsp_ready response out (valid/ready), o_w_err_sticky;
//           AW, W, B, AR, R channel signals towards the AXI4-Lite slave.
// Latency : accept -> rsp_valid is 3 cycles with an always-ready slave.
//           o_w_cmd_ready is the only combinational output (high only in IDLE).

module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_w_aclk,
  input  logic                  i_w_areset_n,

  input  logic                  i_w_cmd_valid,
  output logic                  o_w_cmd_ready,
  input  logic                  i_w_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_w_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_w_cmd_wdata,

  output logic                  o_w_rsp_valid,
  input  logic                  i_w_rsp_ready,
  output logic                  o_w_rsp_write,
  output logic [1:0]            o_w_rsp_resp,
  output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
  output logic                  o_w_err_sticky,

  output logic                  o_w_awvalid,
  input  logic                  i_w_awready,
  output logic [ADDR_WIDTH-1:0] o_w_awaddr,
  output logic                  o_w_wvalid,
  input  logic                  i_w_wready,
  output logic [DATA_WIDTH-1:0] o_w_wdata,
  input  logic                  i_w_bvalid,
  output logic                  o_w_bready,
  input  logic [1:0]            i_w_bresp,

  output logic                  o_w_arvalid,
  input  logic                  i_w_arready,
  output logic [ADDR_WIDTH-1:0] o_w_araddr,
  input  logic                  i_w_rvalid,
  output logic                  o_w_rready,
  input  logic [1:0]            i_w_rresp,
  input  logic [DATA_WIDTH-1:0] i_w_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_AW_W,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_t;

  state_t                r_state;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [1:0]            r_rsp_resp;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_err_sticky;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rsp_hs;

  assign o_w_cmd_ready = (r_state == S_IDLE);

  // Handshakes are qualified by our own registered valid/ready, so slave
  // strobes arriving outside their wait state are ignored.
  assign w_cmd_hs = i_w_cmd_valid & o_w_cmd_ready;
  assign w_aw_hs  = r_awvalid & i_w_awready;
  assign w_w_hs   = r_wvalid & i_w_wready;
  assign w_b_hs   = r_bready & i_w_bvalid;
  assign w_ar_hs  = r_arvalid & i_w_arready;
  assign w_r_hs   = r_rready & i_w_rvalid;
  assign w_rsp_hs = r_rsp_valid & i_w_rsp_ready;

  always_ff @(posedge i_w_aclk or negedge i_w_areset_n) begin
    if (!i_w_areset_n) begin
      r_state      <= S_IDLE;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_resp   <= 2'b00;
      r_rsp_rdata  <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_hs) begin
            r_addr  <= i_w_cmd_addr;
            r_wdata <= i_w_cmd_wdata;
            if (i_w_cmd_write) begin
              r_state   <= S_WR_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RD_AR;
              r_arvalid <= 1'b1;
            end
          end
        end

        // AW and W complete independently; leave once both are done,
        // counting a handshake happening on this very edge.
        S_WR_AW_W: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state  <= S_WR_B;
            r_bready <= 1'b1;
          end
        end

        S_WR_B: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_resp  <= i_w_bresp;
            r_rsp_rdata <= '0;
            if (i_w_bresp != 2'b00) begin
              r_err_sticky <= 1'b1;
            end
            r_state <= S_RSP;
          end
        end

        S_RD_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end

        S_RD_R: begin
          if (w_r_hs) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_resp  <= i_w_rresp;
            r_rsp_rdata <= i_w_rdata;
            if (i_w_rresp != 2'b00) begin
              r_err_sticky <= 1'b1;
            end
            r_state <= S_RSP;
          end
        end

        S_RSP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Address and write data share one register set: only one channel
  // group is ever active at a time.
  assign o_w_awaddr     = r_addr;
  assign o_w_araddr     = r_addr;
  assign o_w_wdata      = r_wdata;
  assign o_w_awvalid    = r_awvalid;
  assign o_w_wvalid     = r_wvalid;
  assign o_w_bready     = r_bready;
  assign o_w_arvalid    = r_arvalid;
  assign o_w_rready     = r_rready;
  assign o_w_rsp_valid  = r_rsp_valid;
  assign o_w_rsp_write  = r_rsp_write;
  assign o_w_rsp_resp   = r_rsp_resp;
  assign o_w_rsp_rdata  = r_rsp_rdata;
  assign o_w_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Purpose : directed bench for axil_cmd_master with a cycle-level slave model.
// Ports   : none (top-level bench).
// Notes   : inputs driven and outputs sampled on the falling clock edge.

module tb_axil_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic        err_sticky;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_w_aclk      (clk),
    .i_w_areset_n  (rst_n),
    .i_w_cmd_valid (cmd_valid),
    .o_w_cmd_ready (cmd_ready),
    .i_w_cmd_write (cmd_write),
    .i_w_cmd_addr  (cmd_addr),
    .i_w_cmd_wdata (cmd_wdata),
    .o_w_rsp_valid (rsp_valid),
    .i_w_rsp_ready (rsp_ready),
    .o_w_rsp_write (rsp_write),
    .o_w_rsp_resp  (rsp_resp),
    .o_w_rsp_rdata (rsp_rdata),
    .o_w_err_sticky(err_sticky),
    .o_w_awvalid   (awvalid),
    .i_w_awready   (awready),
    .o_w_awaddr    (awaddr),
    .o_w_wvalid    (wvalid),
    .i_w_wready    (wready),
    .o_w_wdata     (wdata),
    .i_w_bvalid    (bvalid),
    .o_w_bready    (bready),
    .i_w_bresp     (bresp),
    .o_w_arvalid   (arvalid),
    .i_w_arready   (arready),
    .o_w_araddr    (araddr),
    .i_w_rvalid    (rvalid),
    .o_w_rready    (rready),
    .i_w_rresp     (rresp),
    .i_w_rdata     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // slave read data
    logic [1:0]  resp;      // slave BRESP or RRESP
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          ar_dly;
    int          r_dly;
    int          rsp_dly;
    int          exp_lat;   // cycle of first rsp_valid, accept cycle = 0
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vec[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at the falling
  // edge after the response handshake, again with the DUT in IDLE.
  task automatic run_txn(input vec_t v);
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rs_n = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int lat = -1;
    bit done = 0;
    bit overlap = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if ((awvalid | wvalid | bready) && (arvalid | rready)) overlap = 1;

      awready = awvalid && (aw_n >= v.aw_dly);
      if (awvalid) begin chk("awaddr", awaddr, v.addr); aw_n++; end
      if (awvalid && awready) aw_hs++;

      wready = wvalid && (w_n >= v.w_dly);
      if (wvalid) begin chk("wdata", wdata, v.wdata); w_n++; end
      if (wvalid && wready) w_hs++;

      bvalid = bready && (b_n >= v.b_dly);
      bresp  = v.resp;
      if (bready) b_n++;
      if (bready && bvalid) b_hs++;

      arready = arvalid && (ar_n >= v.ar_dly);
      if (arvalid) begin chk("araddr", araddr, v.addr); ar_n++; end
      if (arvalid && arready) ar_hs++;

      rvalid = rready && (r_n >= v.r_dly);
      rresp  = v.resp;
      rdata  = v.rdata;
      if (rready) r_n++;
      if (rready && rvalid) r_hs++;

      if (rsp_valid) begin
        if (lat < 0) lat = cyc;
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.exp_resp);
        chk("rsp_write", rsp_write, v.write);
        chk("err_sticky", err_sticky, v.exp_err);
        chk("cmd_ready_rsp", cmd_ready, 0);
        rsp_ready = (rs_n >= v.rsp_dly);
        rs_n++;
        if (rsp_ready) done = 1;
      end else begin
        rsp_ready = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
      end
    end
    chk("rsp_done", done, 1);
    chk("latency", lat, v.exp_lat);
    chk("aw_hs", aw_hs, v.write ? 1 : 0);
    chk("w_hs", w_hs, v.write ? 1 : 0);
    chk("b_hs", b_hs, v.write ? 1 : 0);
    chk("ar_hs", ar_hs, v.write ? 0 : 1);
    chk("r_hs", r_hs, v.write ? 0 : 1);
    chk("overlap", overlap, 0);
    @(negedge clk);
    idle_slave();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_again", cmd_ready, 1);
  endtask

  initial begin
    //          wr addr          wdata          rdata          rsp   aw w b ar r rs lat eresp  erdata         eerr
    vec[0] = '{1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         2'b00, 0,0,0,0,0,0, 3, 2'b00, 32'h0,         0};
    vec[1] = '{1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0,         2'b00, 0,3,0,0,0,0, 6, 2'b00, 32'h0,         0};
    vec[2] = '{0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2'b00, 0,0,0,0,4,2, 7, 2'b00, 32'hDEAD_BEEF, 0};
    vec[3] = '{1, 32'h0000_0020, 32'hA5A5_0001, 32'h0,         2'b00, 2,0,1,0,0,0, 6, 2'b00, 32'h0,         0};
    vec[4] = '{0, 32'h0000_0024, 32'h0,         32'h1234_5678, 2'b00, 0,0,0,2,0,0, 5, 2'b00, 32'h1234_5678, 0};
    vec[5] = '{0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 2'b10, 0,0,0,0,0,0, 3, 2'b10, 32'hCAFE_F00D, 1};
    vec[6] = '{1, 32'h0000_0040, 32'h0000_0000, 32'h0,         2'b00, 0,0,0,0,0,0, 3, 2'b00, 32'h0,         1};
    vec[7] = '{1, 32'h0000_0044, 32'h5555_AAAA, 32'h0,         2'b11, 0,0,0,0,0,0, 3, 2'b11, 32'h0,         1};

    idle_slave();
    rsp_ready = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0099;
    cmd_wdata = 32'h1111_1111;
    cmd_valid = 1'b1;        // presented during reset, must not be taken
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_awaddr", awaddr, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awvalid", awvalid, 0);
    chk("post_rst_arvalid", arvalid, 0);

    // Back-to-back: each command is presented on the falling edge where
    // the previous response has just dropped.
    for (int i = 0; i < 8; i++) run_txn(vec[i]);

    // Reset while awvalid waits for awready.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0050;
    cmd_wdata = 32'h1111_2222;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_awvalid", awvalid, 1);
    @(negedge clk);
    chk("mid_awvalid_held", awvalid, 1);
    chk("mid_awaddr_held", awaddr, 32'h0000_0050);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_awvalid", awvalid, 0);
    chk("arst_wvalid", wvalid, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_err", err_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_rst_rsp_valid", rsp_valid, 0);
      chk("after_rst_awvalid", awvalid, 0);
    end

    run_txn(vec[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
